// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encodings,
// port identifiers and the default RAM geometry.
package ram_arbiter_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant. Holds the last-served pointer, which
// moves to the winner whenever the grant is taken.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  req0_i,
  input  logic  req1_i,
  input  logic  take_i,
  output logic  valid_o,
  output port_e sel_o
);

  port_e last_q;
  port_e last_d;

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      sel_o = (last_q == PORT1) ? PORT0 : PORT1;
    end else if (req1_i) begin
      sel_o = PORT1;
    end else begin
      sel_o = PORT0;
    end

    last_d = last_q;
    if (take_i && valid_o) begin
      last_d = sel_o;
    end
  end

  // Pointer resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between a CPU port and a loader
// port. One transaction every four cycles; all outputs are registered.
//
// state      | meaning
// IDLE       | wait for a request, latch the winner's command
// ACCESS     | drive the latched command to the RAM, owner's gnt high
// CAPTURE    | RAM read data valid, register it into the owner's dout
// DONE       | owner's done pulse
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] din0_i,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] din1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          done0_o,
  output logic          done1_o,
  output logic [DW-1:0] dout0_o,
  output logic [DW-1:0] dout1_o,
  output logic          ram_wen_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  state_e        state_q,  state_d;
  port_e         owner_q,  owner_d;
  logic          we_q,     we_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [DW-1:0] din_q,    din_d;
  logic          gnt0_q,   gnt0_d;
  logic          gnt1_q,   gnt1_d;
  logic          done0_q,  done0_d;
  logic          done1_q,  done1_d;
  logic          wen_q,    wen_d;
  logic [DW-1:0] dout0_q,  dout0_d;
  logic [DW-1:0] dout1_q,  dout1_d;

  logic  arb_valid;
  port_e arb_sel;
  logic  arb_take;

  assign arb_take = (state_q == ST_IDLE);

  rr_arbiter2 u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req0_i  (req0_i),
    .req1_i  (req1_i),
    .take_i  (arb_take),
    .valid_o (arb_valid),
    .sel_o   (arb_sel)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    wen_d   = 1'b0;
    dout0_d = dout0_q;
    dout1_d = dout1_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_ACCESS;
          owner_d = arb_sel;
          if (arb_sel == PORT1) begin
            we_d   = we1_i;
            addr_d = addr1_i;
            din_d  = din1_i;
            gnt1_d = 1'b1;
            wen_d  = we1_i;
          end else begin
            we_d   = we0_i;
            addr_d = addr0_i;
            din_d  = din0_i;
            gnt0_d = 1'b1;
            wen_d  = we0_i;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_DONE;
        if (owner_q == PORT1) begin
          done1_d = 1'b1;
          if (!we_q) dout1_d = ram_dout_i;
        end else begin
          done0_d = 1'b1;
          if (!we_q) dout0_d = ram_dout_i;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      wen_q   <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      wen_q   <= wen_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  // Reset arriving in the ACCESS cycle must kill the write at that same edge,
  // so the registered enable is qualified by the reset input.
  assign ram_wen_o  = wen_q & ~rst_i;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = din_q;
  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign done0_o    = done0_q;
  assign done1_o    = done1_q;
  assign dout0_o    = dout0_q;
  assign dout1_o    = dout1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a synchronous RAM model; expected
// values are hand-computed per step.
module tb_ram_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] dout0, dout1;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_rdata;
  logic          mem_clr;
  logic [DW-1:0] mem [32];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req0_i     (req0),
    .we0_i      (we0),
    .addr0_i    (addr0),
    .din0_i     (din0),
    .req1_i     (req1),
    .we1_i      (we1),
    .addr1_i    (addr1),
    .din1_i     (din1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .done0_o    (done0),
    .done1_o    (done1),
    .dout0_o    (dout0),
    .dout1_o    (dout1),
    .ram_wen_o  (ram_wen),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_rdata)
  );

  // Synchronous RAM: write and read-address sampled on the rising edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; din0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    tick();
    mem_clr = 1'b0;
    tick();
    check("rst_gnt0",  gnt0,    0);
    check("rst_gnt1",  gnt1,    0);
    check("rst_done0", done0,   0);
    check("rst_done1", done1,   0);
    check("rst_wen",   ram_wen, 0);
    check("rst_dout0", dout0,   0);
    check("rst_dout1", dout1,   0);
    rst = 1'b0;
    tick();

    // Port 0 write addr 3 <- 0x07
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; din0 = 8'h07;
    tick();
    check("wr_c1_gnt0", gnt0,     1);
    check("wr_c1_gnt1", gnt1,     0);
    check("wr_c1_wen",  ram_wen,  1);
    check("wr_c1_addr", ram_addr, 3);
    check("wr_c1_din",  ram_din,  8'h07);
    tick();
    check("wr_c2_gnt0", gnt0,    0);
    check("wr_c2_wen",  ram_wen, 0);
    check("wr_c2_done0", done0,  0);
    tick();
    check("wr_c3_done0", done0, 1);
    check("wr_c3_done1", done1, 0);
    req0 = 1'b0;
    tick();
    check("wr_c4_done0", done0,  0);
    check("wr_mem3",     mem[3], 8'h07);

    // Port 1 read addr 3
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3;
    tick();
    check("rd1_c1_gnt1", gnt1,    1);
    check("rd1_c1_gnt0", gnt0,    0);
    check("rd1_c1_wen",  ram_wen, 0);
    tick();
    tick();
    check("rd1_c3_done1", done1, 1);
    check("rd1_c3_done0", done0, 0);
    check("rd1_c3_dout1", dout1, 8'h07);
    check("rd1_c3_dout0", dout0, 0);
    req1 = 1'b0;
    tick();

    // Tie out of reset: 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
      check("rr_gnt1", gnt1, (k % 2 == 1) ? 1 : 0);
      tick();
      check("rr_c2_nodone", done0 | done1, 0);
      tick();
      check("rr_done0", done0, (k % 2 == 0) ? 1 : 0);
      check("rr_done1", done1, (k % 2 == 1) ? 1 : 0);
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      check("rr_c4_nodone", done0 | done1, 0);
    end
    check("rr_dout0", dout0, 8'h07);
    check("rr_dout1", dout1, 8'h00);

    // Port 1 arrives while port 0 is in CAPTURE
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    tick();
    check("late_c1_gnt0", gnt0, 1);
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3;
    tick();
    check("late_c3_done0", done0, 1);
    check("late_c3_gnt1",  gnt1,  0);
    check("late_c3_done1", done1, 0);
    req0 = 1'b0;
    tick();
    check("late_c4_gnt1",  gnt1,  0);
    check("late_c4_done0", done0, 0);
    tick();
    check("late_c5_gnt1", gnt1, 1);
    check("late_c5_gnt0", gnt0, 0);
    tick();
    check("late_c6_nodone", done0 | done1, 0);
    tick();
    check("late_c7_done1", done1, 1);
    check("late_c7_done0", done0, 0);
    check("late_c7_dout1", dout1, 8'h07);
    req1 = 1'b0;
    tick();
    check("late_c8_nodone", done0 | done1, 0);

    // Reset in the ACCESS cycle of a write 0x05 to addr 2
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd2; din0 = 8'h05;
    tick();
    check("abort_c1_wen", ram_wen, 1);
    rst = 1'b1; req0 = 1'b0;
    #1;
    check("abort_wen_gated", ram_wen, 0);
    tick();
    check("abort_gnt0",  gnt0,  0);
    check("abort_done0", done0, 0);
    rst = 1'b0;
    tick();
    check("abort_done0_b", done0, 0);
    tick();
    check("abort_done0_c", done0, 0);
    check("abort_mem2",    mem[2], 8'h00);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd2;
    tick();
    tick();
    tick();
    check("abort_rd_done0", done0, 1);
    check("abort_rd_dout0", dout0, 8'h00);
    req0 = 1'b0;
    tick();

    // Top address: write 31 <- 0xFF, then read back
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd31; din0 = 8'hFF;
    tick();
    check("top_wr_addr", ram_addr, 31);
    check("top_wr_wen",  ram_wen,  1);
    tick();
    tick();
    check("top_wr_done0", done0, 1);
    we0 = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("top_rd_done0", done0,   1);
    check("top_rd_dout0", dout0,   8'hFF);
    check("top_mem0",     mem[0],  8'h00);
    check("top_mem31",    mem[31], 8'hFF);
    req0 = 1'b0;
    tick();
    check("end_idle", gnt0 | gnt1 | done0 | done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
